// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int req_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Byte counter holds 0..MAX_BURST inclusive.
    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Start timer counts 0..START_TIMEOUT-1.
    function automatic int tmr_w(input int start_timeout);
        return (start_timeout > 1) ? $clog2(start_timeout) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: first set request after i_last, wrapping around.
// Latency: purely combinational.
// Backpressure: none; o_any is low when no request is set.
//   i_req  : request vector
//   i_last : index granted most recently (lowest priority this round)
//   o_pick : winning index, o_any : at least one request set
module uart_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_pick,
    output logic             o_any
);

    int               w_k;
    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit after
    // i_last overwrites any earlier candidate.
    always_comb begin
        o_pick = '0;
        o_any  = 1'b0;
        w_k    = 0;
        w_idx  = '0;
        for (int off = N; off >= 1; off--) begin
            w_k   = (int'(i_last) + off) % N;
            w_idx = IDX_W'(w_k);
            if (i_req[w_idx]) begin
                o_pick = w_idx;
                o_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams, round-robin per message.
// Latency: grant 1 cycle after request; new_tx_data 1 cycle after each byte transfer.
// Backpressure: req_ready only for the owner in HOLD; one byte in flight, paced on tx_busy.
//   clock/reset        : clock, synchronous active-low reset
//   req_valid/data/last: per-requester byte stream, req_ready accepts a byte
//   tx_data/new_tx_data: byte and start pulse to the UART, tx_busy back from it
//   grant              : one-hot owner, tx_err: sticky start-timeout flag
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_err
);

    localparam int IDX_W = req_idx_w(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_BURST);
    localparam int TMR_W = tmr_w(START_TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    // Timer value on the edge where it steps to START_TIMEOUT-1.
    localparam logic [TMR_W-1:0] TMR_ERR = TMR_W'(START_TIMEOUT - 2);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_last;
    logic [7:0]         r_tx_data;
    logic               r_new;
    logic               r_err;

    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic               w_own_vld;
    logic               w_own_last;
    logic [7:0]         w_own_dat;

    uart_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req  (req_valid),
        .i_last (r_last_grant),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // While granted, r_last_grant is the current owner's index.
    assign w_own_vld  = req_valid[r_last_grant];
    assign w_own_last = req_last[r_last_grant];
    assign w_own_dat  = req_data[{r_last_grant, 3'b000} +: 8];

    always_comb begin
        req_ready = '0;
        if (r_state == HOLD) begin
            req_ready = r_grant & req_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_tmr        <= '0;
            r_last       <= 1'b0;
            r_tx_data    <= '0;
            r_new        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_new <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_last_grant <= w_pick;
                        r_cnt        <= '0;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    // An idle owner keeps the grant; messages are never split
                    // except by the burst limit.
                    if (w_own_vld) begin
                        r_tx_data <= w_own_dat;
                        r_last    <= w_own_last;
                        r_cnt     <= r_cnt + 1'b1;
                        r_new     <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    r_tmr   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                        if (r_tmr == TMR_ERR) begin
                            r_err   <= 1'b1;
                            r_state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_last || (r_cnt == CNT_MAX)) begin
                            r_grant <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new;
    assign tx_err      = r_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (tx_data / new_tx_data / tx_busy interface of the UART top level) between NUM_REQ byte-stream requesters.
- Grants one requester at a time with rotating (round-robin) priority.
- Holds the grant for a whole message (until req_last) or until MAX_BURST bytes have been sent.
- Paces each byte against tx_busy.
- Sits between the command/response engines and the UART top level, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes sent per grant before forced release (1..255)
START_TIMEOUT, 4, cycles to wait for tx_busy to rise after new_tx_data before declaring an error (>=2)

Ports:
clock  in  1  global clock
reset  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  byte on req_data is the last byte of its message
req_ready  out  NUM_REQ  byte accepted this cycle (valid&ready = transfer)
tx_data  out  8  byte to the UART transmitter
new_tx_data  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy
grant  out  NUM_REQ  one-hot current owner; all-zero when idle
tx_err  out  1  sticky: tx_busy never rose within START_TIMEOUT; cleared only by reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs go to 0, state goes to IDLE, byte count goes to 0.
  - last_grant goes to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer abandons the byte; the transmitter is not otherwise signalled.
- States: IDLE, HOLD, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_grant+1 upward with wrap.
  - grant <= onehot(pick), last_grant <= pick, count <= 0, go to HOLD.
  - Arbitration takes one cycle; grant is visible the cycle after the request is seen.
- HOLD:
  - req_ready[g] = req_valid[g] combinationally; all other req_ready bits are 0.
  - On transfer: tx_data <= byte, latch last <= req_last[g], count <= count+1, go to START.
  - If req_valid[g] is low, stay in HOLD and keep the grant. Requesters must complete their messages.
- START:
  - new_tx_data = 1 for exactly this cycle, so the pulse follows the transfer cycle by 1.
  - Timer <= 0, go to WAIT_BUSY.
- WAIT_BUSY:
  - When tx_busy==1, go to WAIT_DONE.
  - Otherwise the timer increments. When the timer reaches START_TIMEOUT-1, set tx_err and go to WAIT_DONE.
- WAIT_DONE: when tx_busy==0:
  - If last==1 or count==MAX_BURST: grant <= 0 and go to IDLE. Release takes effect the next cycle; the next arbitration is the cycle after that.
  - Else go to HOLD.
- tx_data holds its value from capture until the next capture.
- At most one byte is in flight; no new_tx_data is issued while tx_busy==1.
- Simultaneous requests are resolved by the rotating order only. A requester that just released has the lowest priority next.
- A requester deasserting req_valid while not granted is legal. A granted requester changing req_data without a transfer is ignored.
- count is ceil(log2(MAX_BURST+1)) bits wide and never wraps, because it resets on each grant.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE, HOLD, START, WAIT_BUSY, WAIT_DONE)
  - REQ_IDX_W = clog2(NUM_REQ)
  - CNT_W and TMR_W width functions
- One combinational sub-module, uart_rr_pick:
  - inputs: req vector, last index
  - outputs: pick index, any
  - Rotating priority encoder, reused by other bus arbiters.

Test Plan:
1. Reset, then req_valid=4'b0001 with 3-byte message 0x55,0xAA,0x0F (last on 0x0F) -> grant=0001; three new_tx_data pulses with tx_data 0x55,0xAA,0x0F, each issued only after tx_busy has fallen; then grant=0000.
2. req_valid=4'b1111 held, each requester sending single-byte messages -> grant order 0,1,2,3,0.
3. Requester 2 streams 20 bytes without req_last, MAX_BURST=16, requester 1 waiting -> after the 16th byte completes, grant moves to requester 1; requester 2 resumes afterwards with byte 17.
4. UART model holds tx_busy=0 after new_tx_data -> tx_err=1 exactly START_TIMEOUT cycles after the pulse; the FSM continues with the next byte; tx_err stays 1 until reset.
5. Drive reset low during WAIT_DONE -> next cycle grant=0, new_tx_data=0, tx_err=0, req_ready=0; after reset release, requester 0 has priority.
6. Granted requester drops req_valid for 50 cycles mid-message -> grant held, no new_tx_data pulses, no req_ready to others; message resumes and completes normally.
